mac_layer_sched: RTL and testbench
==================================

# mac_layer_sched

Layer sequencer for the parallel MAC datapath. It takes one input vector of N values on a valid/ready stream and writes it into the shared x memory. It then drives P MAC lanes through G = M/P output groups, generating x, weight and bias addresses and the accumulator controls. Each group's P lane results are serialized onto the output stream through a lane-select mux. The block sits between the upstream stream and the P datapath lanes of a generated `layer_M_N_P_T` top, and replaces the per-lane controllers.

## Interface

Parameters:

- M, 4, number of layer outputs; M % P == 0 is required (elaboration error otherwise).
- N, 4, number of layer inputs.
- P, 2, number of parallel MAC lanes.
- G, M/P, derived: number of output groups.

Ports:

- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- s_valid  in  1  upstream data valid.
- s_ready  out  1  ready to accept an input beat.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- wr_en_x  out  1  x memory write enable.
- addr_x  out  max(1,$clog2(N))  x memory address.
- addr_w  out  max(1,$clog2(G*N))  weight ROM address, common to all lanes.
- addr_b  out  max(1,$clog2(G))  bias ROM address, common to all lanes.
- acc_ld  out  1  lane accumulator loads bias + product.
- acc_en  out  1  lane accumulator adds the product.
- relu_en  out  1  lanes apply ReLU to the accumulator this cycle.
- out_sel  out  max(1,$clog2(P))  lane driving data_out.
- busy  out  1  high in any state other than LOAD.

## Operation

- Lane l's weight ROM holds row g*P+l at addresses g*N .. g*N+N-1. Its bias ROM holds row g*P+l at address g.
- The FSM has five states: LOAD, MAC, DRAIN, RELU, OUT.
- The state register is updated on clk. s_ready = (state==LOAD). m_valid = (state==OUT). busy = (state!=LOAD).
- LOAD
  - wr_en_x = s_valid & s_ready (combinational). addr_x = k.
  - k increments on each handshake.
  - On the N-th handshake: k←0, g←0, go to MAC.
  - While not in LOAD, s_valid is ignored and wr_en_x=0.
- MAC
  - Issues N reads, one per cycle, k = 0..N-1: addr_x = k, addr_w = g*N+k, addr_b = g.
  - After k = N-1: k←0, go to DRAIN.
- Pipeline model: memory/ROM read takes 1 cycle, and the product register adds 1 more. Each issue is therefore consumed by the lanes 2 cycles later.
  - A 2-stage shift register {issue_valid, first} produces acc_ld at issue k=0 + 2 cycles.
  - acc_en is produced at each issue k≥1 + 2 cycles.
  - acc_ld and acc_en are never both high.
- DRAIN: lasts 2 cycles. The last acc_en fires in the second DRAIN cycle. Then go to RELU.
- RELU: one cycle with relu_en=1 (clamp negative to 0). Then go to OUT with lane index l=0.
- OUT
  - out_sel = l.
  - On m_valid & m_ready: l increments.
  - On the P-th handshake: if g == G-1, go to LOAD with k=0. Otherwise g←g+1 and go to MAC.
  - While m_ready=0, everything is held: out_sel, g and m_valid stay constant.
- Address counters wrap by FSM control only, never by natural overflow. All counters are unsigned.
- N=1 is legal: MAC lasts one cycle and acc_ld fires with no acc_en.
- P=M is legal: G=1 and addr_b is constant 0.

## Timing

- Reset (reset=0, asynchronous) forces, with no clock edge:
  - state=LOAD, k=0, g=0, l=0, pipeline cleared.
  - s_ready=1, m_valid=0, wr_en_x=0, acc_ld=0, acc_en=0, relu_en=0, busy=0.
  - addr_x=0, addr_w=0, addr_b=0, out_sel=0.
- Deassertion is synchronous to clk. The first handshake is possible on the first edge after deassertion.
- Reset asserted mid-operation discards the vector and partial results. No output beat is produced.
- Per group, with no stall: N (MAC) + 2 (DRAIN) + 1 (RELU) + P (OUT) cycles.
  - The first m_valid rises N+3 cycles after entering MAC.
- The 4-4-2 layer latency from the 4th input handshake to the last output beat, with no stall, is 2×(4+2+1+2) = 18 cycles.
- s_ready rises the cycle after the final output handshake. LOAD of the next vector never overlaps OUT.

## Test plan

- Reset: hold reset=0 with no clk edges. Outputs go to their reset values immediately: s_ready=1, m_valid=0, busy=0.
- Load with gaps (M=4, N=4, P=2): s_valid pattern 1,0,1,1,0,1 with values 85,16,-59,48.
  - wr_en_x pulses exactly 4 times at addr_x 0,1,2,3.
  - s_ready=0 the cycle after the 4th handshake.
  - Extra s_valid in MAC produces no write.
- Group sequencing, m_ready tied 1:
  - addr_w goes 0,1,2,3 (addr_b=0), then after OUT goes 4,5,6,7 (addr_b=1).
  - acc_ld is 2 cycles after the first issue. acc_en pulses 3 times. relu_en pulses once per group.
  - out_sel goes 0,1,0,1. m_valid first rises 7 cycles after MAC entry.
  - s_ready returns 1 exactly 18 cycles after the 4th input handshake.
- Output stall: m_ready=0 for 5 cycles during OUT, lane 1. m_valid=1, out_sel=1 and g are held. Completion happens 5 cycles later than the unstalled run.
- Async reset mid-MAC: assert reset at k=2 of group 1, off-edge. All outputs return to reset values without a clock. After release, a fresh 4-beat load is accepted and sequences from addr_w=0.
- Parameter corners:
  - N=1, M=P=2: one MAC cycle, acc_ld only and no acc_en, 2 output beats per vector.
  - M=3, P=2 fails elaboration.

Source files
------------

// File: rtl/mac_layer_sched.sv
// Layer sequencer: loads one N-value input vector, then steps P MAC lanes through M/P output
// groups and serializes each group's lane results onto the output stream.
module mac_layer_sched #(
    parameter int unsigned M = 4,
    parameter int unsigned N = 4,
    parameter int unsigned P = 2
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        s_valid,
    output logic                                        s_ready,
    output logic                                        m_valid,
    input  logic                                        m_ready,
    output logic                                        wr_en_x,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]         addr_x,
    output logic [((M/P*N > 1) ? $clog2(M/P*N) : 1)-1:0] addr_w,
    output logic [((M/P > 1) ? $clog2(M/P) : 1)-1:0]     addr_b,
    output logic                                        acc_ld,
    output logic                                        acc_en,
    output logic                                        relu_en,
    output logic [((P > 1) ? $clog2(P) : 1)-1:0]         out_sel,
    output logic                                        busy
);
    localparam int unsigned G  = M / P;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned WW = (G * N > 1) ? $clog2(G * N) : 1;
    localparam int unsigned BW = (G > 1) ? $clog2(G) : 1;
    localparam int unsigned LW = (P > 1) ? $clog2(P) : 1;

    localparam logic [KW-1:0] KLast = KW'(N - 1);
    localparam logic [BW-1:0] GLast = BW'(G - 1);
    localparam logic [LW-1:0] LLast = LW'(P - 1);

    if (P == 0 || (M % P) != 0) begin : g_bad_params
        $error("mac_layer_sched: M must be a non-zero multiple of P");
    end

    typedef enum logic [2:0] {StLoad, StMac, StDrain, StRelu, StOut} state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [BW-1:0] g_q, g_d;
    logic [LW-1:0] l_q, l_d;
    logic          drain_q, drain_d;
    // Issue tracking across the memory-read and product-register stages.
    logic [1:0]    pipe_v_q, pipe_f_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StLoad;
            k_q      <= '0;
            g_q      <= '0;
            l_q      <= '0;
            drain_q  <= 1'b0;
            pipe_v_q <= '0;
            pipe_f_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            g_q      <= g_d;
            l_q      <= l_d;
            drain_q  <= drain_d;
            pipe_v_q <= {pipe_v_q[0], state_q == StMac};
            pipe_f_q <= {pipe_f_q[0], (state_q == StMac) && (k_q == '0)};
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        g_d     = g_q;
        l_d     = l_q;
        drain_d = drain_q;

        s_ready = (state_q == StLoad);
        m_valid = (state_q == StOut);
        busy    = (state_q != StLoad);
        relu_en = (state_q == StRelu);
        // Gated by reset so that a held reset never reports a write.
        wr_en_x = s_ready && s_valid && reset;

        unique case (state_q)
            StLoad: begin
                if (s_valid) begin
                    if (k_q == KLast) begin
                        k_d     = '0;
                        g_d     = '0;
                        state_d = StMac;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            StMac: begin
                if (k_q == KLast) begin
                    k_d     = '0;
                    drain_d = 1'b0;
                    state_d = StDrain;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            StDrain: begin
                if (drain_q) begin
                    drain_d = 1'b0;
                    state_d = StRelu;
                end else begin
                    drain_d = 1'b1;
                end
            end
            StRelu: begin
                l_d     = '0;
                state_d = StOut;
            end
            StOut: begin
                if (m_ready) begin
                    if (l_q == LLast) begin
                        l_d = '0;
                        if (g_q == GLast) begin
                            g_d     = '0;
                            k_d     = '0;
                            state_d = StLoad;
                        end else begin
                            g_d     = g_q + BW'(1);
                            state_d = StMac;
                        end
                    end else begin
                        l_d = l_q + LW'(1);
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    assign addr_x  = k_q;
    assign addr_w  = WW'(N * g_q + k_q);
    assign addr_b  = g_q;
    assign out_sel = l_q;
    assign acc_ld  = pipe_v_q[1] & pipe_f_q[1];
    assign acc_en  = pipe_v_q[1] & ~pipe_f_q[1];

endmodule

// File: tb/tb_mac_layer_sched.sv
// Bench for mac_layer_sched: directed latency/stall/reset scenarios plus randomized traffic,
// checked every cycle against a position-in-schedule model of the layer sequence.
module tb_mac_layer_sched;
    localparam int M = 4;
    localparam int N = 4;
    localparam int P = 2;
    localparam int G = M / P;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s_valid = 1'b0;
    logic       m_ready = 1'b1;
    logic       s_ready, m_valid, wr_en_x, acc_ld, acc_en, relu_en, busy;
    logic [1:0] addr_x;
    logic [2:0] addr_w;
    logic [0:0] addr_b;
    logic [0:0] out_sel;

    // Corner instance: N=1, M=P=2.
    logic       s_valid2 = 1'b0;
    logic       m_ready2 = 1'b1;
    logic       s_ready2, m_valid2, wr_en_x2, acc_ld2, acc_en2, relu_en2, busy2;
    logic [0:0] addr_x2, addr_w2, addr_b2, out_sel2;

    always #5 clk = ~clk;

    mac_layer_sched #(.M(M), .N(N), .P(P)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .m_valid(m_valid), .m_ready(m_ready), .wr_en_x(wr_en_x), .addr_x(addr_x),
        .addr_w(addr_w), .addr_b(addr_b), .acc_ld(acc_ld), .acc_en(acc_en),
        .relu_en(relu_en), .out_sel(out_sel), .busy(busy)
    );

    mac_layer_sched #(.M(2), .N(1), .P(2)) dut2 (
        .clk(clk), .reset(reset), .s_valid(s_valid2), .s_ready(s_ready2),
        .m_valid(m_valid2), .m_ready(m_ready2), .wr_en_x(wr_en_x2), .addr_x(addr_x2),
        .addr_w(addr_w2), .addr_b(addr_b2), .acc_ld(acc_ld2), .acc_en(acc_en2),
        .relu_en(relu_en2), .out_sel(out_sel2), .busy(busy2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: either loading (m_cnt beats taken) or at position m_pos of group m_g, where a
    // group is N issue slots, 2 drain, 1 relu, then P output slots.
    int m_loading = 1;
    int m_cnt = 0;
    int m_pos = 0;
    int m_g = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_loading <= 1;
            m_cnt     <= 0;
            m_pos     <= 0;
            m_g       <= 0;
        end else if (m_loading != 0) begin
            if (s_valid) begin
                if (m_cnt == N - 1) begin
                    m_loading <= 0;
                    m_cnt     <= 0;
                    m_pos     <= 0;
                    m_g       <= 0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end else if (!(m_pos >= N + 3 && !m_ready)) begin
            if (m_pos == N + 2 + P) begin
                m_pos <= 0;
                if (m_g == G - 1) begin
                    m_loading <= 1;
                    m_cnt     <= 0;
                    m_g       <= 0;
                end else begin
                    m_g <= m_g + 1;
                end
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (m_loading != 0) begin
                check("s_ready", s_ready, 1);
                check("busy", busy, 0);
                check("m_valid", m_valid, 0);
                check("wr_en_x", wr_en_x, s_valid);
                check("load_addr_x", addr_x, m_cnt);
                check("acc_ld", acc_ld, 0);
                check("acc_en", acc_en, 0);
                check("relu_en", relu_en, 0);
            end else begin
                check("s_ready", s_ready, 0);
                check("busy", busy, 1);
                check("wr_en_x", wr_en_x, 0);
                check("m_valid", m_valid, m_pos >= N + 3);
                check("relu_en", relu_en, m_pos == N + 2);
                check("acc_ld", acc_ld, m_pos == 2);
                check("acc_en", acc_en, m_pos >= 3 && m_pos <= N + 1);
                if (m_pos < N) begin
                    check("mac_addr_x", addr_x, m_pos);
                    check("mac_addr_w", addr_w, m_g * N + m_pos);
                    check("mac_addr_b", addr_b, m_g);
                end
                if (m_pos >= N + 3) check("out_sel", out_sel, m_pos - (N + 3));
            end
        end
    end

    int wr_cnt = 0;
    always @(negedge clk) if (reset && wr_en_x) wr_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_s_ready"}, s_ready, 1);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_wr_en_x"}, wr_en_x, 0);
        check({tag, "_acc_ld"}, acc_ld, 0);
        check({tag, "_acc_en"}, acc_en, 0);
        check({tag, "_relu_en"}, relu_en, 0);
        check({tag, "_addr_x"}, addr_x, 0);
        check({tag, "_addr_w"}, addr_w, 0);
        check({tag, "_addr_b"}, addr_b, 0);
        check({tag, "_out_sel"}, out_sel, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int pat[6];
        int cyc;
        int first_mv;
        int stall_left;
        int stalled;
        int found;
        int n_ld, n_en, n_beats;
        pat = '{1, 0, 1, 1, 0, 1};

        // Reset applied before any clock edge.
        #2;
        check_reset_vals("por");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        step();

        // Gapped load, then unstalled layer timing.
        wr_cnt = 0;
        foreach (pat[i]) begin
            s_valid = pat[i][0];
            step();
        end
        check("s_ready_after_load", s_ready, 0);
        s_valid = 1'b1;
        cyc = 0;
        first_mv = 0;
        while (!s_ready && cyc < 60) begin
            if (cyc == 2) s_valid = 1'b0;
            step();
            cyc++;
            if (m_valid && first_mv == 0) first_mv = cyc;
        end
        s_valid = 1'b0;
        check("first_m_valid_latency", first_mv, 7);
        check("layer_latency", cyc, 18);
        check("write_count", wr_cnt, 4);

        // Stall lane 1 of group 0 for 5 cycles.
        s_valid = 1'b1;
        repeat (4) step();
        s_valid = 1'b0;
        cyc = 0;
        stalled = 0;
        stall_left = 0;
        while (!s_ready && cyc < 80) begin
            if (stall_left == 0 && stalled == 0 && m_valid && out_sel == 1'b1) begin
                stall_left = 5;
                stalled = 1;
            end
            m_ready = (stall_left == 0);
            step();
            cyc++;
            if (stall_left > 0) begin
                check("stall_m_valid", m_valid, 1);
                check("stall_out_sel", out_sel, 1);
                stall_left--;
            end
        end
        m_ready = 1'b1;
        check("stalled_latency", cyc, 23);

        // Asynchronous reset at k=2 of group 1.
        s_valid = 1'b1;
        repeat (4) step();
        s_valid = 1'b0;
        cyc = 0;
        found = 0;
        while (found == 0 && cyc < 40) begin
            step();
            cyc++;
            if (m_loading == 0 && m_g == 1 && m_pos == 2) found = 1;
        end
        check("reached_mid_mac", found, 1);
        check("mid_mac_addr_w", addr_w, 6);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("async");
        @(negedge clk);
        #1;
        reset = 1'b1;
        step();
        s_valid = 1'b1;
        repeat (4) step();
        s_valid = 1'b0;
        check("restart_addr_w", addr_w, 0);
        check("restart_addr_b", addr_b, 0);
        cyc = 0;
        while (!s_ready && cyc < 60) begin
            step();
            cyc++;
        end
        check("restart_latency", cyc, 18);

        // Randomized traffic on both handshakes.
        for (int i = 0; i < 1500; i++) begin
            s_valid = ($urandom_range(0, 9) < 6);
            m_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        cyc = 0;
        while (!s_ready && cyc < 60) begin
            step();
            cyc++;
        end
        check("random_drain_done", s_ready, 1);

        // N=1 corner: one issue, acc_ld only, two output beats.
        check("n1_idle_ready", s_ready2, 1);
        s_valid2 = 1'b1;
        step();
        s_valid2 = 1'b0;
        n_ld = 0;
        n_en = 0;
        n_beats = 0;
        for (int i = 0; i < 10; i++) begin
            if (acc_ld2) n_ld++;
            if (acc_en2) n_en++;
            if (m_valid2 && m_ready2) n_beats++;
            step();
        end
        check("n1_acc_ld_count", n_ld, 1);
        check("n1_acc_en_count", n_en, 0);
        check("n1_beats", n_beats, 2);
        check("n1_back_to_load", s_ready2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
